// File: rtl/ramio_if.sv
// Core-side memory bus of ramio: request fields from the RV32I core, and the
// load result, stall and fault indications returned to it.
interface ramio_if;
    logic        enable;
    logic [31:0] address;
    logic [1:0]  write_type;
    logic [2:0]  read_type;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        data_out_ready;
    logic        busy;
    logic        fault;

    // Core side: issues requests, consumes results.
    modport master (
        output enable, address, write_type, read_type, data_in,
        input  data_out, data_out_ready, busy, fault
    );

    // Adapter side: serves requests.
    modport slave (
        input  enable, address, write_type, read_type, data_in,
        output data_out, data_out_ready, busy, fault
    );
endinterface

// File: rtl/ramio.sv
// ramio: memory access adapter between the RV32I core and the SDRAM line cache.
// Turns byte/half/word loads and stores into word-aligned cache accesses with
// byte masks, decodes the I/O window at the top of the address space
// (0xFFFF_FFFF LED, 0xFFFF_FFFE UART_TX, 0xFFFF_FFFD UART_RX) and hosts the
// UART engines. Optional feature macro: RAMIO_UART_RX_EN builds the receiver;
// without it UART_RX reads 0 and uart_rx is ignored.
module ramio #(
    parameter int ClkFrequencyHz = 27_000_000,
    parameter int BaudRate       = 115_200,
    parameter int LedBitWidth    = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ramio_if.slave                 bus,
    output logic                   cache_enable,
    output logic [31:0]            cache_address,
    output logic [31:0]            cache_data_in,
    output logic [3:0]             cache_write_enable,
    input  logic [31:0]            cache_data_out,
    input  logic                   cache_data_out_ready,
    input  logic                   cache_busy,
    output logic [LedBitWidth-1:0] led,
    output logic                   uart_tx,
    input  logic                   uart_rx
);
    localparam int CyclesPerBit = ClkFrequencyHz / BaudRate;
    localparam int CntW         = (CyclesPerBit > 1) ? $clog2(CyclesPerBit) : 1;
    localparam logic [CntW-1:0] BitLast  = CntW'(CyclesPerBit - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(CyclesPerBit / 2 - 1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);

    typedef enum logic [1:0] {SIZE_NONE, SIZE_BYTE, SIZE_HALF, SIZE_WORD} size_e;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

    function automatic logic misaligned(input size_e size, input logic [1:0] offset);
        return (size == SIZE_HALF && offset[0]) || (size == SIZE_WORD && offset != 2'b00);
    endfunction

    size_e                  wr_size;
    size_e                  rd_size;
    logic                   is_io;
    logic                   sel_led;
    logic                   sel_tx;
    logic                   sel_rx;
    logic                   is_read;
    logic                   is_write;
    logic                   cache_access;
    logic                   io_access;
    logic                   led_wr;
    logic                   tx_wr;
    logic                   rx_rd;
    logic [7:0]             ld_byte;
    logic [15:0]            ld_half;
    logic [7:0]             io_rd_byte;
    logic [7:0]             rx_rd_byte;
    logic [LedBitWidth-1:0] led_d;
    logic [LedBitWidth-1:0] led_q;

    tx_state_e              tx_state_q;
    logic [CntW-1:0]        tx_cnt_q;
    logic [2:0]             tx_idx_q;
    logic [7:0]             tx_shift_q;
    logic                   tx_q;

    // Address decode, store lane steering, load extraction and I/O read mux.
    always_comb begin
        // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
        wr_size  = size_e'(bus.write_type);
        rd_size  = size_e'(bus.read_type[1:0]);
        is_read  = rd_size != SIZE_NONE;
        is_write = wr_size != SIZE_NONE;
        is_io    = (&bus.address[31:2]) && (bus.address[1:0] != 2'b00);
        sel_led  = is_io && bus.address[1:0] == 2'b11;
        sel_tx   = is_io && bus.address[1:0] == 2'b10;
        sel_rx   = is_io && bus.address[1:0] == 2'b01;

        bus.fault    = bus.enable && (misaligned(wr_size, bus.address[1:0]) ||
                                      misaligned(rd_size, bus.address[1:0]));
        cache_access = bus.enable && !is_io && !bus.fault;
        io_access    = bus.enable && is_io && !bus.fault;
        led_wr       = io_access && sel_led && is_write;
        tx_wr        = io_access && sel_tx && is_write;
        rx_rd        = io_access && sel_rx && is_read;

        cache_enable  = cache_access;
        cache_address = {bus.address[31:2], 2'b00};
        unique case (wr_size)
            SIZE_BYTE: begin
                cache_data_in      = {4{bus.data_in[7:0]}};
                cache_write_enable = 4'b0001 << bus.address[1:0];
            end
            SIZE_HALF: begin
                cache_data_in      = {2{bus.data_in[15:0]}};
                cache_write_enable = 4'b0011 << {bus.address[1], 1'b0};
            end
            SIZE_WORD: begin
                cache_data_in      = bus.data_in;
                cache_write_enable = 4'b1111;
            end
            default: begin
                cache_data_in      = bus.data_in;
                cache_write_enable = 4'b0000;
            end
        endcase
        if (!cache_access) begin
            cache_write_enable = 4'b0000;
        end

        io_rd_byte = 8'h00;
        if (sel_led) begin
            io_rd_byte = 8'(led_q);
        end else if (sel_tx) begin
            io_rd_byte = (tx_state_q != TX_IDLE) ? 8'hFF : 8'h00;
        end else if (sel_rx) begin
            io_rd_byte = rx_rd_byte;
        end

        ld_byte = cache_data_out[{bus.address[1:0], 3'b000} +: 8];
        ld_half = cache_data_out[{bus.address[1], 4'b0000} +: 16];
        unique case (rd_size)
            SIZE_BYTE: bus.data_out = {{24{bus.read_type[2] & ld_byte[7]}}, ld_byte};
            SIZE_HALF: bus.data_out = {{16{bus.read_type[2] & ld_half[15]}}, ld_half};
            default:   bus.data_out = cache_data_out;
        endcase
        if (is_io) begin
            bus.data_out = {24'h000000, io_rd_byte};
        end

        bus.busy           = cache_access && cache_busy;
        bus.data_out_ready = is_read && ((cache_access && cache_data_out_ready) || io_access);

        led_d = led_wr ? bus.data_in[LedBitWidth-1:0] : led_q;
    end

    // LED register; a same-cycle read sees the value from before the write.
    always_ff @(posedge clk) begin
        // NOTE: registers use <= so each one samples the values from before the edge.
        if (!rst_n) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

    // UART transmitter: start bit, 8 data bits LSB first, stop bit; writes while busy are dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            unique case (tx_state_q)
                TX_IDLE: begin
                    if (tx_wr) begin
                        tx_state_q <= TX_START;
                        tx_shift_q <= bus.data_in[7:0];
                        tx_cnt_q   <= '0;
                        tx_q       <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_cnt_q == BitLast) begin
                        tx_state_q <= TX_DATA;
                        tx_cnt_q   <= '0;
                        tx_idx_q   <= '0;
                        tx_q       <= tx_shift_q[0];
                        tx_shift_q <= tx_shift_q >> 1;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CntOne;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_q == BitLast) begin
                        tx_cnt_q <= '0;
                        if (tx_idx_q == 3'd7) begin
                            tx_state_q <= TX_STOP;
                            tx_q       <= 1'b1;
                        end else begin
                            tx_idx_q   <= tx_idx_q + 3'd1;
                            tx_q       <= tx_shift_q[0];
                            tx_shift_q <= tx_shift_q >> 1;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CntOne;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt_q == BitLast) begin
                        tx_state_q <= TX_IDLE;
                        tx_cnt_q   <= '0;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CntOne;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

`ifdef RAMIO_UART_RX_EN
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    rx_state_e       rx_state_q;
    logic [CntW-1:0] rx_cnt_q;
    logic [2:0]      rx_idx_q;
    logic [7:0]      rx_shift_q;
    logic [7:0]      rx_data_q;
    logic            rx_meta_q;
    logic            rx_sync_q;
    logic            rx_prev_q;

    // Two-flop synchronizer for the asynchronous line, plus a delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // UART receiver and holding byte; a completed frame wins over a same-cycle read clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
        end else begin
            if (rx_rd) begin
                rx_data_q <= '0;
            end
            unique case (rx_state_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        rx_state_q <= RX_START;
                        rx_cnt_q   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == HalfLast) begin
                        rx_cnt_q   <= '0;
                        rx_idx_q   <= '0;
                        rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CntOne;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == BitLast) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                        if (rx_idx_q == 3'd7) begin
                            rx_state_q <= RX_STOP;
                        end else begin
                            rx_idx_q <= rx_idx_q + 3'd1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CntOne;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == BitLast) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= RX_IDLE;
                        if (rx_sync_q) begin
                            rx_data_q <= rx_shift_q;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CntOne;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    assign rx_rd_byte = rx_data_q;
`else
    logic unused_rx;
    assign unused_rx  = uart_rx ^ rx_rd;
    assign rx_rd_byte = 8'h00;
`endif

    assign led     = led_q;
    assign uart_tx = tx_q;
endmodule

// File: tb/tb_ramio.sv
// Self-checking bench for ramio: directed and randomized cache-path accesses,
// LED, UART TX/RX through the I/O window, and reset behaviour.
module tb_ramio;
    localparam int Cpb  = 4;
    localparam int LedW = 6;
`ifdef RAMIO_UART_RX_EN
    localparam bit RxEn = 1'b1;
`else
    localparam bit RxEn = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cache_enable;
    logic [31:0]     cache_address;
    logic [31:0]     cache_data_in;
    logic [3:0]      cache_write_enable;
    logic [31:0]     cache_data_out = '0;
    logic            cache_data_out_ready = 1'b0;
    logic            cache_busy = 1'b0;
    logic [LedW-1:0] led;
    logic            uart_tx;
    logic            uart_rx = 1'b1;
    int              n_cmp = 0;
    int              n_bad = 0;
    logic [7:0]      rx_model = 8'h00;
    logic [LedW-1:0] led_model = '0;

    ramio_if bus ();

    ramio #(.ClkFrequencyHz(Cpb), .BaudRate(1), .LedBitWidth(LedW)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .bus                  (bus),
        .cache_enable         (cache_enable),
        .cache_address        (cache_address),
        .cache_data_in        (cache_data_in),
        .cache_write_enable   (cache_write_enable),
        .cache_data_out       (cache_data_out),
        .cache_data_out_ready (cache_data_out_ready),
        .cache_busy           (cache_busy),
        .led                  (led),
        .uart_tx              (uart_tx),
        .uart_rx              (uart_rx)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic en, input logic [31:0] a, input logic [1:0] wt,
                         input logic [2:0] rt, input logic [31:0] d);
        bus.enable     = en;
        bus.address    = a;
        bus.write_type = wt;
        bus.read_type  = rt;
        bus.data_in    = d;
    endtask

    task automatic test_reset();
        drive(1'b0, 32'h0, 2'b00, 3'b000, 32'h0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (led !== '0) begin n_bad++; $display("FAIL reset_led: got %h, expected 0", led); end
        n_cmp++; if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b, expected 1", uart_tx); end
        drive(1'b1, 32'hFFFF_FFFE, 2'b00, 3'b001, 32'h0);
        #1;
        n_cmp++; if (bus.data_out !== 32'h0) begin n_bad++; $display("FAIL reset_tx_status: got %h, expected 0", bus.data_out); end
        n_cmp++; if (bus.data_out_ready !== 1'b1) begin n_bad++; $display("FAIL reset_io_ready: got %b, expected 1", bus.data_out_ready); end
        drive(1'b1, 32'hFFFF_FFFD, 2'b00, 3'b001, 32'h0);
        #1;
        n_cmp++; if (bus.data_out !== 32'h0) begin n_bad++; $display("FAIL reset_rx_data: got %h, expected 0", bus.data_out); end
        drive(1'b0, 32'h0, 2'b00, 3'b000, 32'h0);
        rst_n = 1'b1;
    endtask

    task automatic test_cache_directed();
        @(negedge clk);
        cache_busy = 1'b0;
        drive(1'b1, 32'h0000_0013, 2'b01, 3'b000, 32'h0000_00AB);
        #1;
        n_cmp++; if (cache_write_enable !== 4'b1000) begin n_bad++; $display("FAIL sb_mask: got %b, expected 1000", cache_write_enable); end
        n_cmp++; if (cache_data_in !== 32'hABAB_ABAB) begin n_bad++; $display("FAIL sb_data: got %h, expected ababab", cache_data_in); end
        n_cmp++; if (cache_address !== 32'h10) begin n_bad++; $display("FAIL sb_addr: got %h, expected 10", cache_address); end
        n_cmp++; if (cache_enable !== 1'b1) begin n_bad++; $display("FAIL sb_en: got %b, expected 1", cache_enable); end
        cache_data_out = 32'h80FF_1234;
        cache_data_out_ready = 1'b1;
        drive(1'b1, 32'h0000_0002, 2'b00, 3'b110, 32'h0);
        #1;
        n_cmp++; if (bus.data_out !== 32'hFFFF_80FF) begin n_bad++; $display("FAIL lh_signed: got %h, expected ffff80ff", bus.data_out); end
        n_cmp++; if (bus.data_out_ready !== 1'b1) begin n_bad++; $display("FAIL lh_ready: got %b, expected 1", bus.data_out_ready); end
        drive(1'b1, 32'h0000_0000, 2'b00, 3'b001, 32'h0);
        #1;
        n_cmp++; if (bus.data_out !== 32'h0000_0034) begin n_bad++; $display("FAIL lbu: got %h, expected 34", bus.data_out); end
        cache_busy = 1'b1;
        drive(1'b1, 32'h0000_0006, 2'b00, 3'b011, 32'h0);
        #1;
        n_cmp++; if (bus.fault !== 1'b1) begin n_bad++; $display("FAIL lw_fault: got %b, expected 1", bus.fault); end
        n_cmp++; if (cache_enable !== 1'b0) begin n_bad++; $display("FAIL lw_fault_en: got %b, expected 0", cache_enable); end
        n_cmp++; if (bus.data_out_ready !== 1'b0) begin n_bad++; $display("FAIL lw_fault_ready: got %b, expected 0", bus.data_out_ready); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL lw_fault_busy: got %b, expected 0", bus.busy); end
        drive(1'b1, 32'hFFFF_FFFC, 2'b00, 3'b011, 32'h0);
        #1;
        n_cmp++; if (cache_enable !== 1'b1) begin n_bad++; $display("FAIL edge_fffc_en: got %b, expected 1", cache_enable); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL edge_fffc_busy: got %b, expected 1", bus.busy); end
        cache_busy = 1'b0;
        drive(1'b0, 32'h0, 2'b00, 3'b000, 32'h0);
    endtask

    task automatic test_cache_random();
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a, din, cdo, exp_d;
            logic [1:0]  szb;
            logic [3:0]  exp_m;
            logic        wr, sgn, ef;
            int          nb, off;
            longint      val;
            @(negedge clk);
            szb = 2'($urandom_range(1, 3));
            nb  = (szb == 2'd3) ? 4 : int'(szb);
            a   = $urandom;
            if (a >= 32'hFFFF_FFFC) a = a & 32'h0FFF_FFFF;
            if ($urandom_range(0, 1) == 1) a = a & ~32'(nb - 1);
            off = int'(a % 4);
            wr  = 1'($urandom_range(0, 1));
            sgn = 1'($urandom_range(0, 1));
            din = $urandom;
            cdo = $urandom;
            cache_data_out       = cdo;
            cache_busy           = 1'($urandom_range(0, 1));
            cache_data_out_ready = 1'($urandom_range(0, 1));
            drive(1'b1, a, wr ? szb : 2'b00, wr ? 3'b000 : {sgn, szb}, din);
            #1;
            ef = (off % nb) != 0;
            n_cmp++; if (bus.fault !== ef) begin n_bad++; $display("FAIL rnd_fault a=%h: got %b, expected %b", a, bus.fault, ef); end
            n_cmp++; if (cache_enable !== !ef) begin n_bad++; $display("FAIL rnd_en a=%h: got %b, expected %b", a, cache_enable, !ef); end
            n_cmp++; if (cache_address !== (a & 32'hFFFF_FFFC)) begin n_bad++; $display("FAIL rnd_addr: got %h, expected %h", cache_address, a & 32'hFFFF_FFFC); end
            n_cmp++; if (bus.busy !== (!ef && cache_busy)) begin n_bad++; $display("FAIL rnd_busy a=%h: got %b, expected %b", a, bus.busy, !ef && cache_busy); end
            if (wr) begin
                exp_m = ef ? 4'b0000 : 4'(((1 << nb) - 1) << off);
                n_cmp++; if (cache_write_enable !== exp_m) begin n_bad++; $display("FAIL rnd_mask a=%h: got %b, expected %b", a, cache_write_enable, exp_m); end
                n_cmp++; if (bus.data_out_ready !== 1'b0) begin n_bad++; $display("FAIL rnd_wr_ready: got %b, expected 0", bus.data_out_ready); end
                if (!ef) begin
                    exp_d = (nb == 1) ? (din & 32'hFF) * 32'h0101_0101 :
                            (nb == 2) ? (din & 32'hFFFF) * 32'h0001_0001 : din;
                    n_cmp++; if (cache_data_in !== exp_d) begin n_bad++; $display("FAIL rnd_wdata a=%h: got %h, expected %h", a, cache_data_in, exp_d); end
                end
            end else begin
                n_cmp++; if (cache_write_enable !== 4'b0000) begin n_bad++; $display("FAIL rnd_rd_mask: got %b, expected 0000", cache_write_enable); end
                n_cmp++; if (bus.data_out_ready !== (!ef && cache_data_out_ready)) begin n_bad++; $display("FAIL rnd_ready a=%h: got %b, expected %b", a, bus.data_out_ready, !ef && cache_data_out_ready); end
                if (!ef) begin
                    val = cdo;
                    val = val >> (8 * off);
                    if (nb < 4) begin
                        val = val & ((longint'(1) << (8 * nb)) - 1);
                        if (sgn && val >= (longint'(1) << (8 * nb - 1))) val = val - (longint'(1) << (8 * nb));
                    end
                    exp_d = 32'(val);
                    n_cmp++; if (bus.data_out !== exp_d) begin n_bad++; $display("FAIL rnd_load a=%h rt=%b: got %h, expected %h", a, bus.read_type, bus.data_out, exp_d); end
                end
            end
        end
        cache_busy = 1'b0;
        cache_data_out_ready = 1'b0;
        drive(1'b0, 32'h0, 2'b00, 3'b000, 32'h0);
    endtask

    task automatic test_led();
        for (int i = 0; i < 4; i++) begin
            logic [31:0] nv;
            nv = $urandom;
            @(negedge clk);
            drive(1'b1, 32'hFFFF_FFFF, 2'b01, 3'b001, nv);
            #1;
            n_cmp++; if (bus.data_out !== 32'(led_model)) begin n_bad++; $display("FAIL led_same_cycle: got %h, expected %h", bus.data_out, led_model); end
            n_cmp++; if (cache_enable !== 1'b0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL led_io_path: got en=%b busy=%b, expected 0 0", cache_enable, bus.busy); end
            led_model = nv[LedW-1:0];
            @(negedge clk);
            drive(1'b1, 32'hFFFF_FFFF, 2'b00, 3'b001, 32'h0);
            #1;
            n_cmp++; if (led !== led_model) begin n_bad++; $display("FAIL led_pins: got %h, expected %h", led, led_model); end
            n_cmp++; if (bus.data_out !== 32'(led_model)) begin n_bad++; $display("FAIL led_readback: got %h, expected %h", bus.data_out, led_model); end
        end
        drive(1'b0, 32'h0, 2'b00, 3'b000, 32'h0);
    endtask

    task automatic test_uart_tx(input logic [7:0] b);
        logic [9:0] frame;
        logic       exp_bit;
        frame = {1'b1, b, 1'b0};
        @(negedge clk);
        drive(1'b1, 32'hFFFF_FFFE, 2'b01, 3'b000, {8'($urandom), 8'($urandom), 8'($urandom), b});
        for (int i = 0; i < 44; i++) begin
            @(negedge clk);
            if (i == 10) drive(1'b1, 32'hFFFF_FFFE, 2'b01, 3'b000, {24'h0, ~b});
            else         drive(1'b1, 32'hFFFF_FFFE, 2'b00, 3'b001, 32'h0);
            #1;
            exp_bit = (i < 40) ? frame[i / Cpb] : 1'b1;
            n_cmp++; if (uart_tx !== exp_bit) begin n_bad++; $display("FAIL tx_line b=%h cycle %0d: got %b, expected %b", b, i, uart_tx, exp_bit); end
            if (i != 10) begin
                n_cmp++; if (bus.data_out !== ((i < 40) ? 32'hFF : 32'h0)) begin n_bad++; $display("FAIL tx_status cycle %0d: got %h, expected %h", i, bus.data_out, (i < 40) ? 32'hFF : 32'h0); end
            end
        end
        drive(1'b0, 32'h0, 2'b00, 3'b000, 32'h0);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            uart_rx = frame[k];
            repeat (Cpb - 1) @(negedge clk);
        end
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * Cpb) @(negedge clk);
        if (stop) rx_model = b;
    endtask

    task automatic rx_read(input string tag);
        logic [7:0] exp_v;
        exp_v = RxEn ? rx_model : 8'h00;
        @(negedge clk);
        drive(1'b1, 32'hFFFF_FFFD, 2'b00, 3'b001, 32'h0);
        #1;
        n_cmp++; if (bus.data_out !== 32'(exp_v)) begin n_bad++; $display("FAIL %s: got %h, expected %h", tag, bus.data_out, exp_v); end
        rx_model = 8'h00;
        @(negedge clk);
        drive(1'b0, 32'h0, 2'b00, 3'b000, 32'h0);
    endtask

    task automatic test_uart_rx();
        rx_frame(8'hC3, 1'b1);
        rx_read("rx_c3");
        rx_read("rx_cleared");
        rx_frame(8'($urandom), 1'b0);
        rx_read("rx_bad_stop");
        rx_frame(8'h5A, 1'b1);
        rx_frame(8'h96, 1'b1);
        rx_read("rx_overwrite");
        for (int i = 0; i < 3; i++) begin
            rx_frame(8'($urandom), 1'b1);
            rx_read("rx_random");
        end
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clk);
        drive(1'b1, 32'hFFFF_FFFE, 2'b01, 3'b000, 32'h0);
        @(negedge clk);
        drive(1'b1, 32'hFFFF_FFFF, 2'b01, 3'b000, 32'h2A);
        @(negedge clk);
        drive(1'b0, 32'h0, 2'b00, 3'b000, 32'h0);
        repeat (8) @(negedge clk);
        n_cmp++; if (uart_tx !== 1'b0) begin n_bad++; $display("FAIL mid_frame_low: got %b, expected 0", uart_tx); end
        n_cmp++; if (led !== LedW'(6'h2A)) begin n_bad++; $display("FAIL mid_frame_led: got %h, expected 2a", led); end
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL rst_mid_tx: got %b, expected 1", uart_tx); end
        n_cmp++; if (led !== '0) begin n_bad++; $display("FAIL rst_mid_led: got %h, expected 0", led); end
        rst_n = 1'b1;
        led_model = '0;
        repeat (6) @(negedge clk);
        drive(1'b1, 32'hFFFF_FFFE, 2'b00, 3'b001, 32'h0);
        #1;
        n_cmp++; if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL rst_aborted_line: got %b, expected 1", uart_tx); end
        n_cmp++; if (bus.data_out !== 32'h0) begin n_bad++; $display("FAIL rst_aborted_status: got %h, expected 0", bus.data_out); end
        drive(1'b0, 32'h0, 2'b00, 3'b000, 32'h0);
    endtask

    initial begin
        test_reset();
        test_cache_directed();
        test_cache_random();
        test_led();
        test_uart_tx(8'h55);
        test_uart_tx(8'($urandom));
        test_uart_rx();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ramio.md
# ramio

Memory access adapter between the RV32I core and the SDRAM line cache. It converts byte, half-word and signed/unsigned loads and stores into the cache's word-aligned 32-bit accesses with byte write masks. It decodes a small memory-mapped I/O window at the top of the address space (LEDs, UART TX, UART RX) and implements the UART engines. It is the only client of the cache.

## Interface
Parameters:
- `ClkFrequencyHz`, 27_000_000, system clock frequency.
- `BaudRate`, 115_200, UART bit rate; `CYCLES_PER_BIT = ClkFrequencyHz / BaudRate` (integer division).
- `LedBitWidth`, 6, number of LED outputs.

Ports:
- `clk`  in  1  system clock; one clock, all logic on its rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `enable`  in  1  core request valid.
- `address`  in  32  byte address; held by core while `busy`, plus 1 cycle.
- `write_type`  in  2  00 none, 01 byte, 10 half, 11 word.
- `read_type`  in  3  [1:0]: 00 none, 01 byte, 10 half, 11 word; [2]: 1 = sign-extend.
- `data_in`  in  32  store data, right-aligned.
- `data_out`  out  32  load result, right-aligned and extended.
- `data_out_ready`  out  1  `data_out` valid this cycle.
- `busy`  out  1  core must stall.
- `fault`  out  1  misaligned access.
- `cache_enable`, `cache_address[31:0]`, `cache_data_in[31:0]`, `cache_write_enable[3:0]`  out  to cache.
- `cache_data_out[31:0]`, `cache_data_out_ready`, `cache_busy`  in  from cache.
- `led`  out  `LedBitWidth`  LED register.
- `uart_tx`  out  1  serial out.
- `uart_rx`  in  1  serial in, asynchronous.

## Operation
- I/O window: 0xFFFF_FFFF LED (write low bits, read back); 0xFFFF_FFFE UART_TX; 0xFFFF_FFFD UART_RX. All other addresses go to the cache.
- Cache path: `cache_enable = enable && !io && !fault`. `cache_address = {address[31:2], 2'b00}`. `busy = cache_busy`. `data_out_ready = cache_data_out_ready && read_type != 0`.
- Store byte: `cache_data_in = {4{data_in[7:0]}}`, mask `4'b0001 << address[1:0]`. Half: `{2{data_in[15:0]}}`, mask `4'b0011 << 2*address[1]`. Word: mask 1111.
- Load byte: `cache_data_out[8*address[1:0] +: 8]`. Half: `[16*address[1] +: 16]`. Each is zero- or sign-extended per `read_type[2]`.
- `fault` = half access with `address[0]` set, or word access with `address[1:0] != 0`. On fault: no cache enable, `data_out_ready = 0`, `busy = 0`.
- I/O accesses: `busy = 0`, read `data_out_ready = 1`, all combinational. I/O accesses use only bits [7:0] of `data_in` and `data_out`.
- UART_TX read: returns 0 when idle, 0xFF while sending.
  - Write while idle latches the byte and starts a frame: start bit 0, 8 data bits LSB first, stop bit 1, each `CYCLES_PER_BIT` cycles.
  - Write while sending is ignored.
- UART_RX: `uart_rx` passes through a 2-flop synchronizer.
  - A falling edge starts reception; each bit is sampled at its midpoint.
  - On a valid stop bit the byte goes into `rx_data`, overwriting any unread byte. A frame with stop bit 0 is discarded.
  - Read returns `rx_data` (0 = empty). `rx_data` clears on the clock edge that completes the read.

## Timing
- Reset values: `led = 0`, `uart_tx = 1`, TX idle, RX idle, `rx_data = 0`.
- Reset applied mid-frame aborts the frame; `uart_tx` is 1 on the next cycle.
- TX states: Idle → Start → Data[0..7] → Stop → Idle. Stop lasts `CYCLES_PER_BIT`. TX reads as idle from the first cycle after Stop ends.
- RX states: Idle → Start (wait `CYCLES_PER_BIT/2`, recheck 0, else Idle) → Data ×8 → Stop → Idle.
- Byte arrival and RX read in the same cycle: the read returns the old value and the new byte is kept (arrival wins the clear).
- LED write takes effect the cycle after; read-back in the same cycle returns the old value.
- The cache path adds no latency; the whole cache path is combinational.

## Configuration
- `RAMIO_UART_RX_EN` defined: receiver, synchronizer and `rx_data` are built.
- Not defined: UART_RX reads 0, `uart_rx` is ignored, and no RX logic is synthesized.

## Test plan
- Store byte 0xAB at 0x0000_0013 → `cache_write_enable = 1000`, `cache_data_in = 0xABABABAB`, `cache_address = 0x10`.
- Cache returns 0x80FF_1234 for a signed-half load at 0x2 → `data_out = 0xFFFF_80FF`. Unsigned byte load at 0x0 → `0x0000_0034`.
- Word load at 0x6 → `fault = 1`, `cache_enable = 0`, `data_out_ready = 0`, `busy = 0`.
- Write 0x55 to 0xFFFF_FFFE, `CYCLES_PER_BIT = 4`:
  - `uart_tx` shows 0,1,0,1,0,1,0,1,0,1, each level held 4 cycles.
  - UART_TX reads 0xFF during the frame and 0 after.
- Drive a 0xC3 frame on `uart_rx` → UART_RX reads 0xC3, then 0. A frame with stop bit 0 → reads 0.
- Reset asserted mid-TX-frame → next cycle `uart_tx = 1` and `led = 0`.
